// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue
// Brief    : ALU-control decode, ID/EX pipeline register and EX-side operand
//            forwarding with a saturating issued-operation counter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         stall,
    input  logic         flush,
    input  logic [1:0]   alu_op,
    input  logic [5:0]   funct,
    input  logic         alu_src,
    input  logic [N-1:0] rs_data,
    input  logic [N-1:0] rt_data,
    input  logic [N-1:0] imm,
    input  logic [1:0]   fwd_a,
    input  logic [1:0]   fwd_b,
    input  logic [N-1:0] ex_mem_result,
    input  logic [N-1:0] mem_wb_result,
    output logic [N-1:0] inp1,
    output logic [N-1:0] inp2,
    output logic [2:0]   func,
    output logic [N-1:0] store_data,
    output logic         out_valid,
    output logic         illegal,
    output logic [15:0]  issue_count
);

    localparam logic [2:0]  c_ADD = 3'b010;
    localparam logic [2:0]  c_SUB = 3'b110;
    localparam logic [2:0]  c_AND = 3'b000;
    localparam logic [2:0]  c_OR  = 3'b001;
    localparam logic [2:0]  c_SLT = 3'b111;
    localparam logic [2:0]  c_NOP = 3'b011;
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [2:0]   w_func;
    logic         w_illegal;

    logic         r_valid;
    logic [2:0]   r_func;
    logic         r_illegal;
    logic         r_alu_src;
    logic [N-1:0] r_rs;
    logic [N-1:0] r_rt;
    logic [N-1:0] r_imm;
    logic [15:0]  r_issue_count;

    logic [N-1:0] w_fwd_rs;
    logic [N-1:0] w_fwd_rt;
    logic         w_load;

    // ID-side decode; an empty slot always decodes to a clean NOP.
    always_comb begin
        w_func    = c_NOP;
        w_illegal = 1'b0;
        if (in_valid) begin
            case (alu_op)
                2'b00: w_func = c_ADD;
                2'b01: w_func = c_SUB;
                2'b11: w_func = c_SLT;
                default: begin
                    case (funct)
                        6'b100000: w_func = c_ADD;
                        6'b100010: w_func = c_SUB;
                        6'b100100: w_func = c_AND;
                        6'b100101: w_func = c_OR;
                        6'b101010: w_func = c_SLT;
                        default: begin
                            w_func    = c_NOP;
                            w_illegal = 1'b1;
                        end
                    endcase
                end
            endcase
        end
    end

    assign w_load = !flush && !stall;

    // Reset and flush both insert a bubble; stall simply holds.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid   <= 1'b0;
            r_func    <= c_NOP;
            r_illegal <= 1'b0;
            r_alu_src <= 1'b0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_imm     <= '0;
        end else if (!stall) begin
            r_valid   <= in_valid;
            r_func    <= w_func;
            r_illegal <= w_illegal;
            r_alu_src <= alu_src;
            r_rs      <= rs_data;
            r_rt      <= rt_data;
            r_imm     <= imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_count <= '0;
        end else if (w_load && in_valid && !w_illegal && (r_issue_count != c_CNT_MAX)) begin
            r_issue_count <= r_issue_count + 16'd1;
        end
    end

    always_comb begin
        case (fwd_a)
            2'b10:   w_fwd_rs = ex_mem_result;
            2'b01:   w_fwd_rs = mem_wb_result;
            default: w_fwd_rs = r_rs;
        endcase
        case (fwd_b)
            2'b10:   w_fwd_rt = ex_mem_result;
            2'b01:   w_fwd_rt = mem_wb_result;
            default: w_fwd_rt = r_rt;
        endcase
    end

    assign inp1        = w_fwd_rs;
    assign inp2        = r_alu_src ? r_imm : w_fwd_rt;
    assign store_data  = w_fwd_rt;
    assign func        = r_func;
    assign out_valid   = r_valid;
    assign illegal     = r_illegal;
    assign issue_count = r_issue_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue
// Brief    : Table-driven directed bench for alu_issue plus reset-override and
//            counter-saturation sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        alu_src;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] ex_mem_result;
    logic [31:0] mem_wb_result;
    logic [31:0] inp1;
    logic [31:0] inp2;
    logic [2:0]  func;
    logic [31:0] store_data;
    logic        out_valid;
    logic        illegal;
    logic [15:0] issue_count;

    int errors = 0;
    int checks = 0;

    alu_issue #(.N(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .stall         (stall),
        .flush         (flush),
        .alu_op        (alu_op),
        .funct         (funct),
        .alu_src       (alu_src),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .imm           (imm),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .ex_mem_result (ex_mem_result),
        .mem_wb_result (mem_wb_result),
        .inp1          (inp1),
        .inp2          (inp2),
        .func          (func),
        .store_data    (store_data),
        .out_valid     (out_valid),
        .illegal       (illegal),
        .issue_count   (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        st;
        logic        fl;
        logic [1:0]  op;
        logic [5:0]  fn;
        logic        src;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] im;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] exm;
        logic [31:0] mwb;
        logic [2:0]  e_func;
        logic [31:0] e_inp1;
        logic [31:0] e_inp2;
        logic [31:0] e_sd;
        logic        e_ov;
        logic        e_il;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] e_func, input logic [31:0] e_i1,
                             input logic [31:0] e_i2, input logic [31:0] e_sd, input logic e_ov,
                             input logic e_il, input logic [15:0] e_cnt);
        chk({tag, ".func"},  {29'b0, func}, {29'b0, e_func});
        chk({tag, ".inp1"},  inp1, e_i1);
        chk({tag, ".inp2"},  inp2, e_i2);
        chk({tag, ".sdata"}, store_data, e_sd);
        chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, e_ov});
        chk({tag, ".illeg"}, {31'b0, illegal}, {31'b0, e_il});
        chk({tag, ".count"}, {16'b0, issue_count}, {16'b0, e_cnt});
    endtask

    task automatic drive_idle();
        in_valid = 0; stall = 0; flush = 0; alu_op = 2'b00; funct = 6'd0; alu_src = 0;
        rs_data = 0; rt_data = 0; imm = 0; fwd_a = 2'b00; fwd_b = 2'b00;
        ex_mem_result = 0; mem_wb_result = 0;
    endtask

    task automatic load_add(input logic [31:0] a, input logic [31:0] b);
        in_valid = 1; stall = 0; flush = 0; alu_op = 2'b00; alu_src = 0;
        rs_data = a; rt_data = b; fwd_a = 2'b00; fwd_b = 2'b00;
        @(posedge clk); #1;
    endtask

    initial begin
        //              v  st fl op     fn          src rs            rt           imm          fa     fb     exm    mwb    func    inp1          inp2          sd           ov il cnt
        vecs[0]  = '{1, 0, 0, 2'b10, 6'b100010, 0, 32'd7,        32'd3,  32'd0,        2'b00, 2'b00, 32'd0,  32'd0,  3'b110, 32'd7,        32'd3,        32'd3,  1, 0, 16'd1};
        vecs[1]  = '{1, 0, 0, 2'b00, 6'b000000, 1, 32'd100,      32'd9,  32'hFFFFFFFC, 2'b10, 2'b00, 32'd50, 32'd0,  3'b010, 32'd50,       32'hFFFFFFFC, 32'd9,  1, 0, 16'd2};
        vecs[2]  = '{1, 0, 0, 2'b10, 6'b100100, 0, 32'd5,        32'd6,  32'd0,        2'b00, 2'b01, 32'd0,  32'd77, 3'b000, 32'd5,        32'd77,       32'd77, 1, 0, 16'd3};
        vecs[3]  = '{1, 0, 0, 2'b10, 6'b100101, 0, 32'd1,        32'd2,  32'd0,        2'b11, 2'b10, 32'd33, 32'd0,  3'b001, 32'd1,        32'd33,       32'd33, 1, 0, 16'd4};
        vecs[4]  = '{1, 0, 0, 2'b10, 6'b101010, 0, 32'hFFFFFFFF, 32'd2,  32'd0,        2'b00, 2'b00, 32'd0,  32'd0,  3'b111, 32'hFFFFFFFF, 32'd2,        32'd2,  1, 0, 16'd5};
        vecs[5]  = '{1, 0, 0, 2'b01, 6'b000000, 0, 32'd10,       32'd4,  32'd0,        2'b00, 2'b00, 32'd0,  32'd0,  3'b110, 32'd10,       32'd4,        32'd4,  1, 0, 16'd6};
        vecs[6]  = '{1, 0, 0, 2'b10, 6'b000000, 0, 32'd8,        32'd9,  32'd0,        2'b00, 2'b00, 32'd0,  32'd0,  3'b011, 32'd8,        32'd9,        32'd9,  1, 1, 16'd6};
        vecs[7]  = '{0, 0, 0, 2'b00, 6'b000000, 0, 32'd1,        32'd2,  32'd0,        2'b00, 2'b00, 32'd0,  32'd0,  3'b011, 32'd1,        32'd2,        32'd2,  0, 0, 16'd6};
        vecs[8]  = '{1, 0, 0, 2'b11, 6'b000000, 1, 32'd3,        32'd4,  32'd20,       2'b00, 2'b00, 32'd0,  32'd0,  3'b111, 32'd3,        32'd20,       32'd4,  1, 0, 16'd7};
        // three stalled edges with changing inputs: the SLT op must hold
        vecs[9]  = '{1, 1, 0, 2'b00, 6'b000000, 0, 32'd99,       32'd98, 32'd97,       2'b00, 2'b00, 32'd0,  32'd0,  3'b111, 32'd3,        32'd20,       32'd4,  1, 0, 16'd7};
        vecs[10] = '{1, 1, 0, 2'b10, 6'b100000, 0, 32'd55,       32'd56, 32'd57,       2'b00, 2'b00, 32'd0,  32'd0,  3'b111, 32'd3,        32'd20,       32'd4,  1, 0, 16'd7};
        vecs[11] = '{1, 1, 0, 2'b01, 6'b000000, 1, 32'd11,       32'd12, 32'd13,       2'b00, 2'b00, 32'd0,  32'd0,  3'b111, 32'd3,        32'd20,       32'd4,  1, 0, 16'd7};
        vecs[12] = '{1, 1, 1, 2'b00, 6'b000000, 0, 32'd5,        32'd6,  32'd7,        2'b00, 2'b00, 32'd0,  32'd0,  3'b011, 32'd0,        32'd0,        32'd0,  0, 0, 16'd7};
        vecs[13] = '{1, 0, 1, 2'b00, 6'b000000, 1, 32'd5,        32'd6,  32'd7,        2'b00, 2'b00, 32'd0,  32'd0,  3'b011, 32'd0,        32'd0,        32'd0,  0, 0, 16'd7};
        vecs[14] = '{1, 0, 0, 2'b00, 6'b000000, 0, 32'd2,        32'd3,  32'd0,        2'b00, 2'b00, 32'd0,  32'd0,  3'b010, 32'd2,        32'd3,        32'd3,  1, 0, 16'd8};

        drive_idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check_all("reset", 3'b011, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 16'd0);

        for (int i = 0; i < 15; i++) begin
            in_valid = vecs[i].v;   stall = vecs[i].st;   flush = vecs[i].fl;
            alu_op = vecs[i].op;    funct = vecs[i].fn;   alu_src = vecs[i].src;
            rs_data = vecs[i].rs;   rt_data = vecs[i].rt; imm = vecs[i].im;
            fwd_a = vecs[i].fa;     fwd_b = vecs[i].fb;
            ex_mem_result = vecs[i].exm; mem_wb_result = vecs[i].mwb;
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_func, vecs[i].e_inp1, vecs[i].e_inp2,
                      vecs[i].e_sd, vecs[i].e_ov, vecs[i].e_il, vecs[i].e_cnt);
        end

        // reset overrides a concurrent stall
        load_add(32'd21, 32'd22);
        rst = 1; stall = 1; in_valid = 1;
        @(posedge clk); #1;
        rst = 0; stall = 0;
        check_all("rst_stall", 3'b011, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 16'd0);

        // reset overrides a concurrent flush; the flush alone would keep the count
        load_add(32'd4, 32'd5);
        chk("pre_rst_flush.count", {16'b0, issue_count}, 32'd1);
        rst = 1; flush = 1;
        @(posedge clk); #1;
        rst = 0; flush = 0;
        check_all("rst_flush", 3'b011, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 16'd0);

        // drive the counter up to 16'hFFFE, then three more loads must pin it at FFFF
        in_valid = 1; stall = 0; flush = 0; alu_op = 2'b00; alu_src = 0;
        for (int k = 0; k < 65534; k++) @(posedge clk);
        #1;
        chk("sat.pre", {16'b0, issue_count}, 32'h0000FFFE);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("sat.load%0d", k), {16'b0, issue_count}, 32'h0000FFFF);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
